// File: rtl/hilo_mult_ctrl.sv
// HI/LO sequencer around an external unsigned multiplier: MULT/MULTU/MTHI/MTLO,
// sign correction for signed products, and MFHI/MFLO stalling while a product is pending.
module hilo_mult_ctrl #(
  parameter int W           = 32,
  parameter int MUL_LATENCY = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           op_valid,
  input  logic [2:0]     op_code,
  input  logic [W-1:0]   rs_val,
  input  logic [W-1:0]   rt_val,
  output logic           op_ready,
  output logic           busy,
  output logic           done,
  input  logic           mf_req,
  output logic           mf_stall,
  output logic           mul_rst,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_z,
  output logic [W-1:0]   hi,
  output logic [W-1:0]   lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WB
  } state_t;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b010;
  localparam logic [2:0] OP_MTLO  = 3'b011;
  localparam logic [3:0] LAT      = 4'(MUL_LATENCY);

  state_t         state;
  logic [3:0]     cnt;
  logic           neg;
  logic [2*W-1:0] prod;

  // Magnitude of a two's-complement value; the most negative value maps onto itself,
  // which read unsigned is exactly its magnitude.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
    return v[W-1] ? (~v + W'(1)) : v;
  endfunction

  assign prod     = neg ? (~mul_z + (2*W)'(1)) : mul_z;
  assign op_ready = (state == S_IDLE) & reset;
  assign busy     = (state != S_IDLE);
  assign mf_stall = mf_req & busy;
  assign mul_rst  = ~reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      neg   <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (op_valid && op_ready) begin
            unique case (op_code)
              OP_MULTU: begin
                mul_a <= rs_val;
                mul_b <= rt_val;
                neg   <= 1'b0;
                cnt   <= LAT;
                state <= S_WAIT;
              end
              OP_MULT: begin
                mul_a <= magnitude(rs_val);
                mul_b <= magnitude(rt_val);
                neg   <= rs_val[W-1] ^ rt_val[W-1];
                cnt   <= LAT;
                state <= S_WAIT;
              end
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_WB;
        end
        S_WB: begin
          hi    <= prod[2*W-1:W];
          lo    <= prod[W-1:0];
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Randomised and directed bench for hilo_mult_ctrl; products are predicted with plain
// signed/unsigned 64-bit arithmetic and compared against HI/LO after each multiply.
module tb_hilo_mult_ctrl;

  localparam int W   = 32;
  localparam int LAT = 3;

  localparam logic [2:0] MULTU = 3'b000;
  localparam logic [2:0] MULT  = 3'b001;
  localparam logic [2:0] MTHI  = 3'b010;
  localparam logic [2:0] MTLO  = 3'b011;

  logic           clk = 1'b0;
  logic           reset;
  logic           op_valid;
  logic [2:0]     op_code;
  logic [W-1:0]   rs_val;
  logic [W-1:0]   rt_val;
  logic           op_ready;
  logic           busy;
  logic           done;
  logic           mf_req;
  logic           mf_stall;
  logic           mul_rst;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [2*W-1:0] mul_z;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;

  int total_cnt = 0;
  int pass_cnt  = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;
  logic [2*W-1:0] pipe [LAT];

  always #5 clk = ~clk;

  hilo_mult_ctrl #(.W(W), .MUL_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .op_ready(op_ready), .busy(busy),
    .done(done), .mf_req(mf_req), .mf_stall(mf_stall), .mul_rst(mul_rst),
    .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z), .hi(hi), .lo(lo)
  );

  // Stand-in for the external multiplier: unsigned product delayed by LAT edges.
  always @(posedge clk) begin
    if (mul_rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= 64'(mul_a) * 64'(mul_b);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mul_z = pipe[LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ref_product(input logic [2:0] code,
                                              input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    if (code == MULT) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return 64'(a) * 64'(b);
  endfunction

  // Entered and left at a falling edge; leaves the bench in the done cycle so a
  // following call exercises back-to-back acceptance.
  task automatic run_mult(input string tag, input logic [2:0] code, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit hold_mtlo, input logic [W-1:0] mtlo_val);
    logic [63:0] p;
    int busy_cycles;
    int stall_cycles;
    int guard;
    p = ref_product(code, a, b);
    check({tag, " ready"}, 64'(op_ready), 64'd1);
    op_valid = 1'b1; op_code = code; rs_val = a; rt_val = b; mf_req = 1'b1;
    @(negedge clk);
    if (hold_mtlo) begin
      op_code = MTLO; rs_val = mtlo_val;
    end else begin
      op_valid = 1'b0;
    end
    busy_cycles = 0; stall_cycles = 0; guard = 0;
    while (busy && guard < 40) begin
      busy_cycles++;
      if (mf_stall) stall_cycles++;
      check({tag, " ready_busy"}, 64'(op_ready), 64'd0);
      check({tag, " done_busy"}, 64'(done), 64'd0);
      if (hold_mtlo) check({tag, " lo_held"}, 64'(lo), 64'(exp_lo));
      guard++;
      @(negedge clk);
    end
    exp_hi = p[63:32];
    exp_lo = p[31:0];
    check({tag, " busy_cycles"}, 64'(busy_cycles), 64'(LAT + 1));
    check({tag, " stall_cycles"}, 64'(stall_cycles), 64'(LAT + 1));
    check({tag, " busy_end"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " stall_done"}, 64'(mf_stall), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    mf_req = 1'b0;
    if (hold_mtlo) begin
      @(negedge clk);
      op_valid = 1'b0;
      exp_lo = mtlo_val;
      check({tag, " mtlo_lo"}, 64'(lo), 64'(exp_lo));
      check({tag, " mtlo_hi"}, 64'(hi), 64'(exp_hi));
      check({tag, " done_after"}, 64'(done), 64'd0);
      check({tag, " busy_after"}, 64'(busy), 64'd0);
    end
  endtask

  // Moves into HI or LO; caller clears op_valid.
  task automatic move_to(input string tag, input logic [2:0] code, input logic [W-1:0] v);
    op_valid = 1'b1; op_code = code; rs_val = v;
    @(negedge clk);
    if (code == MTHI) exp_hi = v;
    if (code == MTLO) exp_lo = v;
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " hi"}, 64'(hi), 64'd0);
    check({tag, " lo"}, 64'(lo), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
    check({tag, " op_ready"}, 64'(op_ready), 64'd0);
    check({tag, " mul_rst"}, 64'(mul_rst), 64'd1);
  endtask

  initial begin
    logic [W-1:0] edges [5];
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [2:0]   rc;
    edges[0] = 32'h0000_0000; edges[1] = 32'h0000_0001; edges[2] = 32'h7FFF_FFFF;
    edges[3] = 32'h8000_0000; edges[4] = 32'hFFFF_FFFF;

    reset = 1'b0; op_valid = 1'b0; op_code = '0; rs_val = '0; rt_val = '0; mf_req = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("por");
    check("por mul_a", 64'(mul_a), 64'd0);
    check("por mul_b", 64'(mul_b), 64'd0);
    reset = 1'b1;
    #1;
    check("por release op_ready", 64'(op_ready), 64'd1);
    @(negedge clk);

    // MTHI/MTLO on consecutive edges, then an undefined opcode
    move_to("mthi", MTHI, 32'h1234_5678);
    move_to("mtlo", MTLO, 32'h9ABC_DEF0);
    move_to("op111", 3'b111, 32'hDEAD_BEEF);
    op_valid = 1'b0;

    // Reset mid-idle clears the moved values
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("idle_rst");
    exp_hi = '0; exp_lo = '0;
    reset = 1'b1;
    #1;
    check("idle_rst release op_ready", 64'(op_ready), 64'd1);
    @(negedge clk);

    run_mult("multu_ff", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0);
    run_mult("mult_neg5x3", MULT, 32'hFFFF_FFFB, 32'h0000_0003, 1'b0, '0);
    run_mult("mult_min_min", MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, '0);
    run_mult("mult_max_min", MULT, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, '0);
    run_mult("multu_3x4_mtlo", MULTU, 32'h0000_0003, 32'h0000_0004, 1'b1, 32'h0000_BEEF);

    for (int n = 0; n < 24; n++) begin
      rc = 3'($urandom_range(0, 1));
      ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : W'($urandom);
      run_mult($sformatf("rand%0d", n), rc, ra, rb, 1'b0, '0);
    end
    @(negedge clk);
    check("done_pulse_end", 64'(done), 64'd0);

    // Reset while a multiply is waiting on the multiplier
    op_valid = 1'b1; op_code = MULTU; rs_val = 32'd2; rt_val = 32'd2;
    @(negedge clk);
    op_valid = 1'b0;
    check("abort busy", 64'(busy), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("abort");
    exp_hi = '0; exp_lo = '0;
    reset = 1'b1;
    #1;
    check("abort mul_rst released", 64'(mul_rst), 64'd0);
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      check("abort no_done", 64'(done), 64'd0);
      check("abort no_busy", 64'(busy), 64'd0);
    end
    run_mult("after_abort", MULTU, 32'd2, 32'd3, 1'b0, '0);
    check("after_abort lo6", 64'(lo), 64'd6);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
